// File: rtl/mem_io_responder_if.sv
// rtl/mem_io_responder_if.sv - MAR/MDR request/response bus between CPU control and the responder
`timescale 1ns/1ps
interface mem_io_responder_if;
  logic        MEM_EN;
  logic        WE;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] MDR_In;
  logic        R;

  modport master (
    output MEM_EN,
    output WE,
    output MAR,
    output MDR,
    input  MDR_In,
    input  R
  );

  modport slave (
    input  MEM_EN,
    input  WE,
    input  MAR,
    input  MDR,
    output MDR_In,
    output R
  );
endinterface

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - wait-state memory/IO responder: word RAM, SW/HEX registers at 0xFFFF
// Optional feature macro LED_MMIO_EN adds the LED register at 0xFFFE.
`timescale 1ns/1ps
module mem_io_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_io_responder_if.slave bus,
  input  logic [15:0]       SW,
  output logic [15:0]       HEX_OUT
`ifdef LED_MMIO_EN
  ,
  output logic [11:0]       LED
`endif
);

  localparam logic [15:0] HEX_ADDR = 16'hFFFF;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);
`ifdef LED_MMIO_EN
  localparam logic [15:0] LED_ADDR = 16'hFFFE;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        we_q, we_d;
  logic        r_q, r_d;
  logic [15:0] hex_q, hex_d;
  logic [15:0] mmio_rd_q, mmio_rd_d;
  logic        sel_ram_q, sel_ram_d;
`ifdef LED_MMIO_EN
  logic [11:0] led_q, led_d;
`endif

  logic              access;
  logic              is_hex;
  logic              is_led;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_dout_q;
  logic [15:0]       ram [2**ADDR_W];

  always_comb begin
    is_hex   = (addr_q == HEX_ADDR);
`ifdef LED_MMIO_EN
    is_led   = (addr_q == LED_ADDR);
`else
    is_led   = 1'b0;
`endif
    ram_addr = addr_q[ADDR_W-1:0];
    access   = (state_q == ST_WAIT) && bus.MEM_EN && (cnt_q == 4'd0);
    // Gated by reset so a request interrupted by reset never reaches the RAM.
    ram_we   = access && we_q && !is_hex && !is_led && reset;
    ram_re   = access && !we_q && !is_hex && !is_led;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = we_q;
    r_d       = r_q;
    hex_d     = hex_q;
    mmio_rd_d = mmio_rd_q;
    sel_ram_d = sel_ram_q;
`ifdef LED_MMIO_EN
    led_d     = led_q;
`endif
    case (state_q)
      ST_IDLE: begin
        r_d = 1'b0;
        if (bus.MEM_EN) begin
          addr_d  = bus.MAR;
          data_d  = bus.MDR;
          we_d    = bus.WE;
          cnt_d   = WAIT_CNT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.MEM_EN) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_DONE;
          r_d     = 1'b1;
          if (we_q) begin
            if (is_hex) hex_d = data_q;
`ifdef LED_MMIO_EN
            if (is_led) led_d = data_q[11:0];
`endif
          end else if (is_hex) begin
            mmio_rd_d = SW;
            sel_ram_d = 1'b0;
`ifdef LED_MMIO_EN
          end else if (is_led) begin
            mmio_rd_d = {4'h0, led_q};
            sel_ram_d = 1'b0;
`endif
          end else begin
            sel_ram_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!bus.MEM_EN) begin
          state_d = ST_IDLE;
          r_d     = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        r_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 16'h0000;
      data_q    <= 16'h0000;
      we_q      <= 1'b0;
      r_q       <= 1'b0;
      hex_q     <= 16'h0000;
      mmio_rd_q <= 16'h0000;
      sel_ram_q <= 1'b0;
`ifdef LED_MMIO_EN
      led_q     <= 12'h000;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      r_q       <= r_d;
      hex_q     <= hex_d;
      mmio_rd_q <= mmio_rd_d;
      sel_ram_q <= sel_ram_d;
`ifdef LED_MMIO_EN
      led_q     <= led_d;
`endif
    end
  end

  // Plain single-port RAM with an enabled output register, kept free of reset for block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= data_q;
    if (ram_re) ram_dout_q <= ram[ram_addr];
  end

  assign bus.MDR_In = sel_ram_q ? ram_dout_q : mmio_rd_q;
  assign bus.R      = r_q;
  assign HEX_OUT    = hex_q;
`ifdef LED_MMIO_EN
  assign LED        = led_q;
`endif

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory/IO responder on the far side of the CPU's MAR/MDR memory interface.
- Accepts a read or write request from the datapath/control, inserts programmable wait states, and performs the access on an internal word-addressed RAM or a memory-mapped IO register.
- Returns read data on MDR_In and asserts the ready handshake R, which control polls before leaving its memory states.

Parameters:
- ADDR_W, 10, RAM address width; RAM depth is 2^ADDR_W 16-bit words.
- WAIT_STATES, 2, extra cycles inserted before each access completes; legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- MEM_EN  in  1  request valid; held high by control until R is seen.
- WE  in  1  1 = write, 0 = read; sampled with the request.
- MAR  in  16  word address.
- MDR  in  16  write data.
- SW  in  16  switch inputs, readable at 0xFFFF.
- MDR_In  out  16  read data to the datapath MDR mux.
- R  out  1  ready; access is complete.
- HEX_OUT  out  16  display register, written at 0xFFFF.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, R=0, MDR_In=0x0000, HEX_OUT=0x0000, wait counter=0.
  - RAM contents are not cleared.
  - Reset mid-request abandons the request; no write occurs.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If MEM_EN==1 at an edge, latch MAR, MDR and WE into internal registers.
  - Load the 4-bit counter with WAIT_STATES and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If MEM_EN==0, abort to IDLE with no access performed and R stays 0.
  - Else if counter!=0, decrement the counter.
  - Else perform the access and go to DONE.
- Access rules (use latched values only):
  - Read, address 0xFFFF: MDR_In<=SW.
  - Read, other addresses: MDR_In<=RAM[addr[ADDR_W-1:0]].
  - Write, address 0xFFFF: HEX_OUT<=data; the RAM is not written.
  - Write, other addresses: RAM[addr[ADDR_W-1:0]]<=data; MDR_In is unchanged.
  - Upper address bits above ADDR_W alias, except the MMIO addresses.
- DONE:
  - R=1. MDR_In is held stable for the whole time R=1.
  - Stay in DONE while MEM_EN==1.
  - When MEM_EN==0, go to IDLE and R<=0 at that edge.
  - A new request needs at least one cycle in IDLE.
- Latency: request sampled at edge k; R is high after edge k+1+WAIT_STATES. With WAIT_STATES=0, R is high after edge k+1.
- Changes on MAR, MDR or WE after the sampling edge have no effect on the current access.
- The RAM is single-port and synchronous, inferable as block RAM.
- R is registered, never combinational from MEM_EN.

Optional Feature:
- Macro LED_MMIO_EN.
- When defined:
  - Adds output port LED [11:0] with reset value 0x000.
  - A write to address 0xFFFE sets LED<=data[11:0] and does not write RAM.
  - A read of 0xFFFE returns {4'b0, LED}.
- When undefined: no LED port, and 0xFFFE is an ordinary aliased RAM location.

Test Plan:
- Reset low for 2 cycles, then high: R=0, MDR_In=0x0000, HEX_OUT=0x0000, state IDLE.
- Write 0x1234 to 0x0003 (WAIT_STATES=2), then read 0x0003: each R rises 3 edges after MEM_EN is sampled; the read gives MDR_In=0x1234, held while MEM_EN stays high.
- SW=0xBEEF, read 0xFFFF -> MDR_In=0xBEEF. Then write 0x00A5 to 0xFFFF -> HEX_OUT=0x00A5, and RAM[0x3FF] is unchanged (read back the previous value).
- Write 0x5555 to 0x0010, then start a write of 0xAAAA to 0x0010 and drop MEM_EN after 1 WAIT cycle -> R never asserts; a subsequent read returns 0x5555.
- Aliasing with ADDR_W=10: write 0x7777 to 0x0405, then read 0x0005 -> 0x7777.
- Back-to-back reads with WAIT_STATES=0: R rises 1 edge after each request, falls the edge after MEM_EN drops, and the next request is accepted after one IDLE cycle.
- With LED_MMIO_EN defined: write 0xFABC to 0xFFFE -> LED=0xABC; read 0xFFFE -> 0x0ABC.
